mem_wb_stage: RTL

- MEM-stage and WB-stage pipeline registers of the 5-stage CPU, directly upstream of the forwarding mux.
- Accepts retired EX results and performs the data-memory access through a req/ack handshake, stalling EX while it waits.
- Drives the stage-4 forwarding triple (data4/rw4/we4) and the stage-5 forwarding/register-file write triple (data5/rw5/we5).

---
 rtl/cpu_pipe_pkg.sv | 37 +++
 rtl/mem_wb_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cpu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pipe_pkg
// Shared types and constants for the MEM/WB end of the 5-stage CPU pipeline.
//   DATA_W      : datapath and data-memory word width
//   REG_AW      : register-number width
//   mem_state_e : data-memory access FSM state (IDLE, ACCESS)
//   mem_stage_t : MEM pipeline register contents
//   wb_stage_t  : WB pipeline register contents
// -----------------------------------------------------------------------------
package cpu_pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sdata;
    logic [REG_AW-1:0] rw;
    logic              we;
    logic              mrd;
    logic              mwr;
  } mem_stage_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] rw;
    logic              we;
  } wb_stage_t;

endpackage

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// MEM and WB pipeline registers. Takes retired EX results, performs the
// data-memory access over a req/ack handshake (stalling EX while waiting) and
// drives the stage-4 and stage-5 forwarding triples. Stage 5 is also the
// register-file write port.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   ex_*                : EX hand-over (ex_valid/ex_ready) and instruction fields
//   dm_*                : data-memory request/ack interface
//   data4/rw4/we4       : MEM-stage forwarding triple
//   data5/rw5/we5       : WB forwarding triple / register-file write
//   stall_cnt           : cycles with ex_valid & ~ex_ready (only with
//                         MEM_STALL_STATS_EN defined)
//   dbg_state           : current access FSM state (0 = IDLE, 1 = ACCESS)
//
// Handshakes
//   EX -> MEM : a transfer happens on a cycle with ex_valid & ex_ready.
//               ex_ready is combinational and rises in the same cycle the
//               instruction in MEM completes, so back-to-back flow is 1/cycle.
//   MEM -> DM : dm_req is held, with dm_wr/dm_addr/dm_wdata stable, until the
//               cycle dm_ack is seen; ack may arrive in the request cycle.
//               dm_ack while dm_req is low has no effect.
//
// Configuration macro: MEM_STALL_STATS_EN adds the stall_cnt output/counter.
// -----------------------------------------------------------------------------
module mem_wb_stage
  import cpu_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [DATA_W-1:0] ex_sdata,
  input  logic [REG_AW-1:0] ex_rw,
  input  logic              ex_we,
  input  logic              ex_mrd,
  input  logic              ex_mwr,
  output logic              dm_req,
  output logic              dm_wr,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [DATA_W-1:0] data4,
  output logic [DATA_W-1:0] rw4,
  output logic              we4,
  output logic [DATA_W-1:0] data5,
  output logic [DATA_W-1:0] rw5,
  output logic              we5,
`ifdef MEM_STALL_STATS_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              dbg_state
);

  mem_stage_t r_mem;
  wb_stage_t  r_wb;
  mem_state_e r_state;
  mem_state_e w_state_next;

  logic w_memop;
  logic w_complete;
  logic w_load;

  // A memory op completes only on ack; anything else completes the cycle
  // it sits in MEM.
  assign w_memop    = r_mem.valid & (r_mem.mrd | r_mem.mwr);
  assign w_complete = r_mem.valid & (~w_memop | dm_ack);
  assign ex_ready   = ~r_mem.valid | w_complete;
  assign w_load     = ex_valid & ex_ready;

  // MEM register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
    end else if (w_load) begin
      r_mem.valid <= 1'b1;
      r_mem.alu   <= ex_alu;
      r_mem.sdata <= ex_sdata;
      r_mem.rw    <= ex_rw;
      r_mem.we    <= ex_we;
      r_mem.mrd   <= ex_mrd;
      r_mem.mwr   <= ex_mwr;
    end else if (w_complete) begin
      r_mem.valid <= 1'b0;
    end
  end

  // WB register: a cycle without completion leaves a bubble behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb <= '0;
    end else begin
      r_wb.valid <= w_complete;
      if (w_complete) begin
        r_wb.rw   <= r_mem.rw;
        r_wb.we   <= r_mem.we;
        r_wb.data <= r_mem.mrd ? dm_rdata : r_mem.alu;
      end
    end
  end

  // Access FSM: tracks whether a request is waiting. The request itself is
  // derived from memop, so reset drops dm_req immediately and a late ack
  // finds no request to complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (dm_req && !dm_ack) w_state_next = ACCESS;
      ACCESS:  if (dm_ack)            w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign dbg_state = r_state;

  // Memory interface: all fields come straight from the MEM register, so
  // they cannot change while the request is held.
  assign dm_req   = w_memop;
  assign dm_wr    = r_mem.valid & r_mem.mwr;
  assign dm_addr  = r_mem.alu;
  assign dm_wdata = r_mem.sdata;

  // Forwarding. A load in MEM only holds its address, so it never forwards.
  assign data4 = r_mem.alu;
  assign rw4   = {{(DATA_W-REG_AW){1'b0}}, r_mem.rw};
  assign we4   = r_mem.valid & r_mem.we & ~r_mem.mrd;
  assign data5 = r_wb.data;
  assign rw5   = {{(DATA_W-REG_AW){1'b0}}, r_wb.rw};
  assign we5   = r_wb.valid & r_wb.we;

`ifdef MEM_STALL_STATS_EN
  logic [31:0] r_stall_cnt;

  // Free-running; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (ex_valid && !ex_ready) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
